rr_arbiter_dataless: RTL and testbench
======================================

// Module: rr_arbiter_dataless
// PURPOSE
//  Round-robin arbiter that shares one dataless handshake channel among NUM_INPUTS requesters.
//  It sits in front of a shared dataless buffer or FIFO. It emits the winning input's index
//  alongside the token so downstream logic can steer or merge.
//  Grants persist: once a token is offered downstream, the offer stays unchanged until it transfers.
// PARAMETERS
//  NUM_INPUTS   default 4  number of requesters; must be >= 1 (non-power-of-two allowed)
//  INDEX_WIDTH  default 2  width of index output; must be >= max(1, clog2(NUM_INPUTS))
// PORTS
//  clk         in   1            clock; all state updates on rising edge
//  rst         in   1            synchronous, active-high reset
//  ins_valid   in   NUM_INPUTS   per-requester valid
//  ins_ready   out  NUM_INPUTS   per-requester ready; at most one bit high
//  outs_valid  out  1            shared channel valid
//  outs_ready  in   1            shared channel ready from consumer
//  index       out  INDEX_WIDTH  binary id of the input currently offered; meaningful only when outs_valid=1
// BEHAVIOUR
//  State
//   - ptr: priority pointer, range 0..NUM_INPUTS-1.
//   - state: IDLE or LOCKED.
//   - lock_idx: the input held while LOCKED.
//  Reset
//   - While rst=1, outputs are forced: outs_valid=0, ins_ready=0, index=0.
//   - Next edge: ptr<=0, state<=IDLE, lock_idx<=0.
//  IDLE
//   - winner = first i with ins_valid[i]=1, scanning ptr, ptr+1, ... mod NUM_INPUTS.
//   - outs_valid=|ins_valid; index=winner (0 if none).
//   - ins_ready[winner]=outs_ready; all other ins_ready bits are 0.
//   - Transfer (outs_valid & outs_ready): ptr<=(winner+1) mod NUM_INPUTS; stay IDLE.
//   - Stall (outs_valid & !outs_ready): state<=LOCKED, lock_idx<=winner; ptr unchanged.
//  LOCKED
//   - index=lock_idx; outs_valid=ins_valid[lock_idx].
//   - ins_ready[lock_idx]=outs_ready; all others 0.
//   - New or higher-priority requests are ignored until the held token transfers.
//   - On transfer: ptr<=(lock_idx+1) mod NUM_INPUTS; state<=IDLE.
//  Timing
//   - Zero latency valid->valid and ready->ready (combinational paths).
//   - Throughput: 1 token/cycle when outs_ready=1.
//  Wrap-around
//   - ptr wraps from NUM_INPUTS-1 to 0, never to 2^INDEX_WIDTH-1.
//   - index never exceeds NUM_INPUTS-1.
//  Fairness
//   - With all requesters continuously valid, each is served once per NUM_INPUTS transfers.
//   - Any continuously valid requester is granted within NUM_INPUTS transfers.
//  Protocol violation
//   - Case: ins_valid[lock_idx] drops while LOCKED.
//   - Response: outs_valid=0, lock held; simulation assertion fires.
//  Reset mid-operation
//   - Any lock is discarded and ptr returns to 0.
//   - No ins_ready is asserted in the rst cycle.
//  NUM_INPUTS=1
//   - Degenerates to pass-through: index=0, ptr fixed at 0.
// TESTING
//  1. Rotation: rst, then ins_valid=4'b1111, outs_ready=1 for 8 cycles
//     -> index 0,1,2,3,0,1,2,3; ins_ready one-hot matching index; one transfer per cycle.
//  2. Lock: ins_valid=4'b0100, outs_ready=0 for 3 cycles; ins_valid[0] rises in cycle 2
//     -> index=2 throughout; ins_ready=0.
//     Then outs_ready=1 -> ins_ready=4'b0100; next cycle index=0.
//  3. Non-power-of-two: NUM_INPUTS=3, INDEX_WIDTH=2, ins_valid=3'b111, outs_ready=1
//     -> index 0,1,2,0,1,2; index==3 never observed.
//  4. Sparse skip: ptr=1 (after serving 0), only ins_valid[3]=1
//     -> grant index=3; after transfer ptr=0, so index=0 next when all valid.
//  5. Reset mid-lock: locked on 2 with outs_ready=0; assert rst one cycle
//     -> outs_valid=0, ins_ready=0 during rst.
//     Next cycle with ins_valid=4'b1111: index=0.
//  6. Random fairness: 2000 cycles, all ins_valid held, random outs_ready
//     -> per-input transfer counts differ by <=1; ins_ready never multi-hot; no assertion fires.

Source files
------------

// File: rtl/rr_arbiter_dataless.sv
// rr_arbiter_dataless
//   Round-robin arbiter sharing one dataless valid/ready channel among
//   NUM_INPUTS requesters. The winning input's index travels with the token.
//   Once an offer is stalled, it is held unchanged until it transfers.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | winner chosen combinationally, scanning from ptr upward
//   LOCKED  | offer stalled; lock_idx held until its token transfers
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset; forces all outputs to 0
//   ins_valid_i   per-requester valid
//   ins_ready_o   per-requester ready, at most one bit high
//   outs_valid_o  shared channel valid
//   outs_ready_i  shared channel ready from the consumer
//   index_o       id of the input currently offered
module rr_arbiter_dataless #(
  parameter int NUM_INPUTS  = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_INPUTS-1:0]  ins_valid_i,
  output logic [NUM_INPUTS-1:0]  ins_ready_o,
  output logic                   outs_valid_o,
  input  logic                   outs_ready_i,
  output logic [INDEX_WIDTH-1:0] index_o
);

  typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] lock_idx_q, lock_idx_d;

  logic [INDEX_WIDTH-1:0] win_idx;
  logic [INDEX_WIDTH-1:0] sel_idx;
  logic                   sel_valid;
  logic                   xfer;

  // Position of the requester 'off' steps after 'base', wrapping at NUM_INPUTS.
  function automatic int rot_pos(input logic [INDEX_WIDTH-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= NUM_INPUTS) ? s - NUM_INPUTS : s;
  endfunction

  // Wrap at NUM_INPUTS-1, not at the natural 2^INDEX_WIDTH boundary.
  function automatic logic [INDEX_WIDTH-1:0] inc_wrap(input logic [INDEX_WIDTH-1:0] idx);
    return (int'(idx) >= NUM_INPUTS - 1) ? '0 : idx + INDEX_WIDTH'(1);
  endfunction

  // Scan from the farthest offset down so the nearest valid one to ptr wins.
  always_comb begin
    win_idx = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (ins_valid_i[rot_pos(ptr_q, k)]) begin
        win_idx = INDEX_WIDTH'(rot_pos(ptr_q, k));
      end
    end
  end

  always_comb begin
    sel_idx   = (state_q == S_LOCKED) ? lock_idx_q : win_idx;
    sel_valid = (state_q == S_LOCKED) ? ins_valid_i[lock_idx_q] : |ins_valid_i;
    xfer      = sel_valid & outs_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          ptr_d = inc_wrap(win_idx);
        end else if (sel_valid) begin
          state_d    = S_LOCKED;
          lock_idx_d = win_idx;
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          ptr_d   = inc_wrap(lock_idx_q);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ins_ready_o  = '0;
    outs_valid_o = 1'b0;
    index_o      = '0;
    if (!rst_i) begin
      outs_valid_o         = sel_valid;
      index_o              = sel_idx;
      ins_ready_o[sel_idx] = outs_ready_i;
    end
  end

  // A held requester must keep its valid up until its token transfers.
  a_lock_valid_held: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == S_LOCKED) |-> ins_valid_i[lock_idx_q]
  );

endmodule

// File: tb/tb_rr_arbiter_dataless.sv
module tb_rr_arbiter_dataless;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] va;
  logic [3:0] rdy_a;
  logic       ov_a;
  logic       ra;
  logic [1:0] idx_a;
  logic [2:0] vb;
  logic [2:0] rdy_b;
  logic       ov_b;
  logic       rb;
  logic [1:0] idx_b;

  int checks   = 0;
  int failures = 0;

  // reference model state, [0] = 4-input instance, [1] = 3-input instance
  int n_in[2]     = '{4, 3};
  int m_ptr[2];
  bit m_locked[2];
  int m_lock[2];

  // last observed values of instance A, for directed checks
  logic [1:0] obs_idx_a;
  logic [3:0] obs_rdy_a;
  logic       obs_ov_a;
  logic [1:0] obs_idx_b;
  int         cnt[4];

  always #5 clk_i = ~clk_i;

  rr_arbiter_dataless #(.NUM_INPUTS(4), .INDEX_WIDTH(2)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .ins_valid_i(va), .ins_ready_o(rdy_a),
    .outs_valid_o(ov_a), .outs_ready_i(ra), .index_o(idx_a)
  );

  rr_arbiter_dataless #(.NUM_INPUTS(3), .INDEX_WIDTH(2)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .ins_valid_i(vb), .ins_ready_o(rdy_b),
    .outs_valid_o(ov_b), .outs_ready_i(rb), .index_o(idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input int n, input int ptr, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return 0;
  endfunction

  // Expected outputs of instance d for the given inputs, then state update.
  task automatic model(input int d, input logic [3:0] v, input logic r, input logic rst,
                       output logic e_ov, output logic [3:0] e_rdy, output int e_idx,
                       output bit e_xfer);
    int w;
    w = winner(n_in[d], m_ptr[d], v);
    if (rst) begin
      e_ov = 1'b0; e_rdy = 4'b0; e_idx = 0;
    end else begin
      e_idx = m_locked[d] ? m_lock[d] : w;
      e_ov  = m_locked[d] ? v[m_lock[d]] : (v != 4'b0);
      e_rdy = 4'b0;
      e_rdy[e_idx] = r;
    end
    e_xfer = e_ov & r;
    if (rst) begin
      m_ptr[d] = 0; m_locked[d] = 1'b0; m_lock[d] = 0;
    end else if (e_xfer) begin
      m_ptr[d] = (e_idx + 1) % n_in[d]; m_locked[d] = 1'b0;
    end else if (e_ov && !m_locked[d]) begin
      m_locked[d] = 1'b1; m_lock[d] = w;
    end
  endtask

  task automatic cyc(input logic [3:0] v_a, input logic r_a, input logic [2:0] v_b,
                     input logic r_b, input logic rst);
    logic       e_ov;
    logic [3:0] e_rdy;
    int         e_idx;
    bit         e_xfer;
    rst_i = rst; va = v_a; ra = r_a; vb = v_b; rb = r_b;
    @(negedge clk_i);
    obs_idx_a = idx_a; obs_rdy_a = rdy_a; obs_ov_a = ov_a; obs_idx_b = idx_b;
    model(0, v_a, r_a, rst, e_ov, e_rdy, e_idx, e_xfer);
    chk("a_valid", 32'(ov_a), 32'(e_ov));
    chk("a_ready", 32'(rdy_a), 32'(e_rdy));
    chk("a_index", 32'(idx_a), e_idx);
    chk("a_ready_onehot", 32'($countones(rdy_a) <= 1), 32'd1);
    if (e_xfer && e_idx < 4) cnt[e_idx]++;
    model(1, {1'b0, v_b}, r_b, rst, e_ov, e_rdy, e_idx, e_xfer);
    chk("b_valid", 32'(ov_b), 32'(e_ov));
    chk("b_ready", 32'(rdy_b), 32'(e_rdy[2:0]));
    chk("b_index", 32'(idx_b), e_idx);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [3:0] rv;
    logic [2:0] rvb;
    int         mx, mn;

    // reset
    cyc(4'hF, 1'b1, 3'b111, 1'b1, 1'b1);
    chk("rst_valid", 32'(obs_ov_a), 32'd0);
    chk("rst_ready", 32'(obs_rdy_a), 32'd0);
    cyc(4'h0, 1'b0, 3'b000, 1'b0, 1'b1);

    // rotation
    for (int i = 0; i < 8; i++) begin
      cyc(4'hF, 1'b1, 3'b000, 1'b0, 1'b0);
      chk("rot_index", 32'(obs_idx_a), i % 4);
      chk("rot_ready", 32'(obs_rdy_a), 32'(1) << (i % 4));
    end

    // lock on 2, later request on 0 ignored
    cyc(4'b0100, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("lock_index_c1", 32'(obs_idx_a), 32'd2);
    chk("lock_ready_c1", 32'(obs_rdy_a), 32'd0);
    cyc(4'b0101, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("lock_index_c2", 32'(obs_idx_a), 32'd2);
    cyc(4'b0101, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("lock_index_c3", 32'(obs_idx_a), 32'd2);
    chk("lock_ready_c3", 32'(obs_rdy_a), 32'd0);
    cyc(4'b0101, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("lock_release_ready", 32'(obs_rdy_a), 32'b0100);
    cyc(4'b0101, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("after_lock_index", 32'(obs_idx_a), 32'd0);

    // sparse skip from ptr=1 to 3, then wrap to 0
    cyc(4'b1000, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("sparse_index", 32'(obs_idx_a), 32'd3);
    cyc(4'hF, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("sparse_wrap_index", 32'(obs_idx_a), 32'd0);

    // reset while locked
    cyc(4'b0100, 1'b0, 3'b000, 1'b0, 1'b0);
    chk("prerst_lock_index", 32'(obs_idx_a), 32'd2);
    cyc(4'hF, 1'b1, 3'b000, 1'b0, 1'b1);
    chk("midrst_valid", 32'(obs_ov_a), 32'd0);
    chk("midrst_ready", 32'(obs_rdy_a), 32'd0);
    cyc(4'hF, 1'b1, 3'b000, 1'b0, 1'b0);
    chk("postrst_index", 32'(obs_idx_a), 32'd0);

    // non-power-of-two rotation
    for (int i = 0; i < 6; i++) begin
      cyc(4'h0, 1'b0, 3'b111, 1'b1, 1'b0);
      chk("np2_index", 32'(obs_idx_b), i % 3);
    end

    // random valids/readies, keeping held valids asserted
    for (int i = 0; i < 600; i++) begin
      rv  = 4'($urandom);
      rvb = 3'($urandom);
      if (m_locked[0]) rv[m_lock[0]] = 1'b1;
      if (m_locked[1]) rvb[m_lock[1]] = 1'b1;
      cyc(rv, 1'($urandom), rvb, 1'($urandom), 1'b0);
    end

    // fairness under random backpressure
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc(4'hF, 1'($urandom), 3'b111, 1'($urandom), 1'b0);
    end
    mx = cnt[0]; mn = cnt[0];
    for (int i = 1; i < 4; i++) begin
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] < mn) mn = cnt[i];
    end
    chk("fair_spread_le1", 32'(mx - mn <= 1), 32'd1);
    chk("fair_nonzero", 32'(mn > 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
